// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and op-class decode.
package muldiv_pkg;

   typedef enum logic [3:0] {
      MD_NOP   = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MADD  = 4'd5,
      MD_MADDU = 4'd6,
      MD_MSUB  = 4'd7,
      MD_MSUBU = 4'd8,
      MD_MTHI  = 4'd9,
      MD_MTLO  = 4'd10
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_ITER = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   typedef struct packed {
      logic is_mul;
      logic is_div;
      logic is_signed;
      logic is_accum;
      logic is_sub;
   } op_class_t;

   // Accumulate ops collapse to an empty class (NOP) when accumulation is disabled.
   function automatic op_class_t decode_op(input md_op_e op, input logic accum_en);
      op_class_t c;
      c = '0;
      case (op)
         MD_MULT:  begin c.is_mul = 1'b1; c.is_signed = 1'b1; end
         MD_MULTU: begin c.is_mul = 1'b1; end
         MD_DIV:   begin c.is_div = 1'b1; c.is_signed = 1'b1; end
         MD_DIVU:  begin c.is_div = 1'b1; end
         MD_MADD:  if (accum_en) begin c.is_mul = 1'b1; c.is_signed = 1'b1; c.is_accum = 1'b1; end
         MD_MADDU: if (accum_en) begin c.is_mul = 1'b1; c.is_accum = 1'b1; end
         MD_MSUB:  if (accum_en) begin c.is_mul = 1'b1; c.is_signed = 1'b1; c.is_accum = 1'b1; c.is_sub = 1'b1; end
         MD_MSUBU: if (accum_en) begin c.is_mul = 1'b1; c.is_accum = 1'b1; c.is_sub = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide over WIDTH steps.
// hi holds the partial product / remainder, lo the multiplier / quotient bits.
module muldiv_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a_mag,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    count_q;
   logic             is_div_q;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic             add_sub;
   logic [WIDTH+1:0] add_sum;

   // Select adder operands: divide compares the shifted remainder against the divisor,
   // multiply conditionally adds the multiplicand to the upper half.
   always_comb begin
      add_sub = is_div_q;
      add_x   = {1'b0, hi};
      add_y   = '0;
      if (is_div_q) begin
         add_x = {hi, lo[WIDTH-1]};
         add_y = {1'b0, b_q};
      end else if (lo[0]) begin
         add_y = {1'b0, b_q};
      end
   end

   // One shared adder/subtractor; bit WIDTH+1 is the no-borrow flag when subtracting.
   assign add_sum = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}}
                  + {{(WIDTH+1){1'b0}}, add_sub};

   // Load operands, then one shift step per cycle while the counter runs down.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi       <= '0;
         lo       <= '0;
         b_q      <= '0;
         count_q  <= '0;
         is_div_q <= 1'b0;
      end else if (load) begin
         hi       <= '0;
         lo       <= a_mag;
         b_q      <= b_mag;
         count_q  <= CW'(WIDTH - 1);
         is_div_q <= is_div;
      end else if (step) begin
         if (is_div_q) begin
            hi <= add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], add_sum[WIDTH+1]};
         end else begin
            hi <= add_sum[WIDTH:1];
            lo <= {add_sum[0], lo[WIDTH-1:1]};
         end
         count_q <= count_q - 1'b1;
      end
   end

   assign last = (count_q == '0);

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit owning the HI/LO pair, with stall/abort handshakes.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting; MTHI/MTLO complete here in one edge
//   ST_PREP | operand magnitudes into core, latch signs and HI:LO snapshot
//   ST_ITER | WIDTH shift-add / restoring-subtract steps
//   ST_FIX  | apply signs / accumulate / div-by-zero, write HI:LO
module muldiv_hilo_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit ACCUM_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             abort,
   input  logic             mf_req,
   input  logic             mf_sel,
   output logic [WIDTH-1:0] mf_data,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero
);

   md_state_e        state_q, state_d;
   op_class_t        cls, cls_q;
   logic             accept;
   logic [WIDTH-1:0] a_q, b_q;
   logic             neg_lo_q, neg_hi_q;
   logic [2*WIDTH-1:0] snap_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, div_zero_q;
   logic             core_load, core_step, core_last;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [2*WIDTH-1:0] prod, prod_s, fix_result;

   assign cls    = decode_op(op, ACCUM_EN);
   assign busy   = (state_q != ST_IDLE);
   assign accept = start & ~abort & ~busy;
   assign stall  = busy & (start | mf_req);
   assign mf_data  = mf_sel ? hi_q : lo_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

   assign a_mag = (cls_q.is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
   assign b_mag = (cls_q.is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and core control; abort drops any in-flight op back to idle.
   always_comb begin
      state_d   = state_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         ST_IDLE: if (accept && (cls.is_mul || cls.is_div)) state_d = ST_PREP;
         ST_PREP: begin core_load = 1'b1; state_d = ST_ITER; end
         ST_ITER: begin core_step = 1'b1; if (core_last) state_d = ST_FIX; end
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (core_load),
      .step   (core_step),
      .is_div (cls_q.is_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .hi     (core_hi),
      .lo     (core_lo),
      .last   (core_last)
   );

   // Final HI:LO value: sign fixup, accumulate against the snapshot, divide-by-zero override.
   always_comb begin
      prod       = {core_hi, core_lo};
      prod_s     = neg_lo_q ? (~prod + 1'b1) : prod;
      fix_result = prod_s;
      if (cls_q.is_accum) fix_result = cls_q.is_sub ? (snap_q - prod_s) : (snap_q + prod_s);
      if (cls_q.is_div) begin
         if (b_q == '0) fix_result = {a_q, {WIDTH{1'b1}}};
         else           fix_result = {(neg_hi_q ? (~core_hi + 1'b1) : core_hi),
                                      (neg_lo_q ? (~core_lo + 1'b1) : core_lo)};
      end
   end

   // Latch the request at accept, signs and snapshot in PREP.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cls_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         snap_q   <= '0;
      end else if (state_q == ST_IDLE && accept) begin
         cls_q <= cls;
         a_q   <= src_a;
         b_q   <= src_b;
      end else if (state_q == ST_PREP) begin
         neg_lo_q <= cls_q.is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
         neg_hi_q <= cls_q.is_signed & a_q[WIDTH-1];
         snap_q   <= {hi_q, lo_q};
      end
   end

   // Architectural HI/LO, done pulse and div_zero flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept && op == MD_MTHI) hi_q <= src_a;
         if (accept && op == MD_MTLO) lo_q <= src_a;
         if (state_q == ST_FIX && !abort) begin
            {hi_q, lo_q} <= fix_result;
            done_q       <= 1'b1;
            if (cls_q.is_div) div_zero_q <= (b_q == '0);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit (WIDTH=32) against a plain-arithmetic HI/LO model.
module tb_muldiv_hilo_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, abort, mf_req, mf_sel;
   md_op_e       op;
   logic [W-1:0] src_a, src_b, mf_data;
   logic         busy, stall, done, div_zero;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_hi, m_lo;
   logic         m_dz;

   muldiv_hilo_unit #(.WIDTH(W), .ACCUM_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .abort(abort), .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data),
      .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Reference model: architectural effect of one op using 64-bit integer arithmetic.
   task automatic model_op(input md_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      logic [63:0] hl, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hl = {m_hi, m_lo};
      case (o)
         MD_MULT:  hl = 64'(sa * sb);
         MD_MULTU: hl = {32'b0, a} * {32'b0, b};
         MD_MADD:  begin p = 64'(sa * sb); hl = hl + p; end
         MD_MADDU: begin p = {32'b0, a} * {32'b0, b}; hl = hl + p; end
         MD_MSUB:  begin p = 64'(sa * sb); hl = hl - p; end
         MD_MSUBU: begin p = {32'b0, a} * {32'b0, b}; hl = hl - p; end
         MD_DIV, MD_DIVU: begin
            if (b == 0) begin
               hl = {a, 32'hFFFF_FFFF}; m_dz = 1'b1;
            end else if (o == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               hl = {32'h0, 32'h8000_0000}; m_dz = 1'b0;
            end else if (o == MD_DIV) begin
               hl = {32'(sa % sb), 32'(sa / sb)}; m_dz = 1'b0;
            end else begin
               hl = {a % b, a / b}; m_dz = 1'b0;
            end
         end
         MD_MTHI: hl[63:32] = a;
         MD_MTLO: hl[31:0]  = a;
         default: ;
      endcase
      {m_hi, m_lo} = hl;
   endtask

   task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
      mf_sel = 1'b1; #1; hi = mf_data;
      mf_sel = 1'b0; #1; lo = mf_data;
   endtask

   // Issue one iterative op and wait for done; returns latency (cycles after accept edge).
   task automatic run_op(input md_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt, output logic [W-1:0] hi,
                         output logic [W-1:0] lo, output logic dz);
      @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1; start = 1'b0; op = MD_NOP;
      lat = 1; bcnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk); #1; lat++;
      end
      read_hilo(hi, lo);
      dz = div_zero;
   endtask

   task automatic run_mt(input md_op_e o, input logic [W-1:0] a);
      @(negedge clk); start = 1'b1; op = o; src_a = a; src_b = '0;
      @(posedge clk); #1; start = 1'b0; op = MD_NOP;
   endtask

   task automatic test_reset();
      logic [W-1:0] hi, lo;
      reset = 1'b0; start = 1'b1; op = MD_MULT; src_a = 32'd3; src_b = 32'd4;
      abort = 1'b0; mf_req = 1'b1; mf_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      @(negedge clk); start = 1'b0; op = MD_NOP; mf_req = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h:%h exp 0:0", hi, lo); end
      checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b dz=%b exp 0 0", done, div_zero); end
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
   endtask

   // Directed cases from the datasheet examples, including latency and busy length.
   task automatic test_directed();
      md_op_e ops[5] = '{MD_MULT, MD_DIVU, MD_DIV, MD_DIV, MD_DIV};
      logic [W-1:0] as[5] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
      logic [W-1:0] bs[5] = '{32'd5, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [W-1:0] eh[5] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h0};
      logic [W-1:0] el[5] = '{32'hFFFF_FFF1, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
      logic         ez[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int lat, bcnt;
      logic [W-1:0] hi, lo;
      logic dz;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], lat, bcnt, hi, lo, dz);
         model_op(ops[i], as[i], bs[i]);
         checks++; if (lat !== W + 3) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, W + 3); end
         checks++; if (bcnt !== W + 2) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, bcnt, W + 2); end
         checks++; if (hi !== eh[i] || lo !== el[i]) begin errors++; $display("FAIL dir%0d_hilo got %h:%h exp %h:%h", i, hi, lo, eh[i], el[i]); end
         if (i > 0) begin
            checks++; if (dz !== ez[i]) begin errors++; $display("FAIL dir%0d_div_zero got %b exp %b", i, dz, ez[i]); end
         end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %b exp 0", i, done); end
      end
   endtask

   task automatic test_accum();
      int lat, bcnt;
      logic [W-1:0] hi, lo;
      logic dz;
      run_mt(MD_MTHI, 32'h0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
      run_mt(MD_MTLO, 32'hFFFF_FFFF);
      model_op(MD_MTHI, 32'h0, 32'h0);
      model_op(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mt_visible got %h:%h exp 00000000:ffffffff", hi, lo); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mt_done got %b exp 0", done); end
      run_op(MD_MADDU, 32'd1, 32'd1, lat, bcnt, hi, lo, dz);
      model_op(MD_MADDU, 32'd1, 32'd1);
      checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL maddu got %h:%h exp 00000001:00000000", hi, lo); end
      run_op(MD_MSUB, 32'd2, 32'd1, lat, bcnt, hi, lo, dz);
      model_op(MD_MSUB, 32'd2, 32'd1);
      checks++; if (hi !== 32'd0 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL msub got %h:%h exp 00000000:fffffffe", hi, lo); end
   endtask

   // MFHI while a MULT is in flight: stall through FIX, new HI readable in the done cycle.
   task automatic test_mf_stall();
      logic [W-1:0] a, b;
      int bad;
      a = $urandom; b = $urandom;
      @(negedge clk); start = 1'b1; op = MD_MULT; src_a = a; src_b = b;
      @(posedge clk); #1; start = 1'b0; op = MD_NOP; mf_req = 1'b1; mf_sel = 1'b1;
      model_op(MD_MULT, a, b);
      bad = 0;
      for (int k = 1; k <= W + 2; k++) begin
         if (stall !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mf_stall_high got %0d low cycles exp 0", bad); end
      checks++; if (stall !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mf_stall_release got stall=%b done=%b exp 0 1", stall, done); end
      checks++; if (mf_data !== m_hi) begin errors++; $display("FAIL mf_data_hi got %h exp %h", mf_data, m_hi); end
      mf_req = 1'b0; mf_sel = 1'b0;
   endtask

   // Second request held on start while the first is busy; accepted once busy drops.
   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, hi, lo;
      int lat, st_bad;
      a1 = $urandom; b1 = $urandom_range(1, 1000); a2 = $urandom; b2 = $urandom;
      @(negedge clk); start = 1'b1; op = MD_DIVU; src_a = a1; src_b = b1;
      @(posedge clk); #1; op = MD_MULTU; src_a = a2; src_b = b2;
      model_op(MD_DIVU, a1, b1);
      lat = 1; st_bad = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (stall !== 1'b1) st_bad++;
         @(posedge clk); #1; lat++;
      end
      checks++; if (lat !== W + 3 || st_bad != 0) begin errors++; $display("FAIL b2b_first got lat=%0d stall_gaps=%0d exp %0d 0", lat, st_bad, W + 3); end
      read_hilo(hi, lo);
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_first_hilo got %h:%h exp %h:%h", hi, lo, m_hi, m_lo); end
      @(posedge clk); #1; start = 1'b0; op = MD_NOP;
      model_op(MD_MULTU, a2, b2);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      read_hilo(hi, lo);
      checks++; if (lat !== W + 3) begin errors++; $display("FAIL b2b_second_latency got %0d exp %0d", lat, W + 3); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_second_hilo got %h:%h exp %h:%h", hi, lo, m_hi, m_lo); end
   endtask

   task automatic test_abort();
      logic [W-1:0] hi, lo;
      int dcnt;
      @(negedge clk); start = 1'b1; op = MD_MULT; src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1; start = 1'b0; op = MD_NOP;
      repeat (9) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      dcnt = 0;
      for (int k = 0; k < W + 6; k++) begin
         if (done === 1'b1) dcnt++;
         @(posedge clk); #1;
      end
      checks++; if (dcnt != 0) begin errors++; $display("FAIL abort_done got %0d pulses exp 0", dcnt); end
      read_hilo(hi, lo);
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL abort_hilo got %h:%h exp %h:%h", hi, lo, m_hi, m_lo); end
      // abort together with start: not accepted, MTHI included
      @(negedge clk); start = 1'b1; abort = 1'b1; op = MD_MTHI; src_a = m_hi ^ 32'h5A5A_5A5A;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0; op = MD_NOP;
      read_hilo(hi, lo);
      checks++; if (hi !== m_hi || busy !== 1'b0) begin errors++; $display("FAIL abort_start got hi=%h busy=%b exp %h 0", hi, busy, m_hi); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] hi, lo;
      @(negedge clk); start = 1'b1; op = MD_DIV; src_a = $urandom; src_b = 32'd0;
      @(posedge clk); #1; start = 1'b0; op = MD_NOP;
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      read_hilo(hi, lo);
      checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_mid got busy=%b hilo=%h:%h exp 0 0:0", busy, hi, lo); end
      @(negedge clk); reset = 1'b1;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      repeat (W + 4) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_mid_flags got done=%b dz=%b exp 0 0", done, div_zero); end
   endtask

   task automatic test_random();
      md_op_e pool[10] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD,
                           MD_MADDU, MD_MSUB, MD_MSUBU, MD_MTHI, MD_MTLO};
      md_op_e o;
      logic [W-1:0] a, b, hi, lo;
      logic dz;
      int lat, bcnt;
      for (int n = 0; n < 40; n++) begin
         o = pool[$urandom_range(0, 9)];
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         if (o == MD_MTHI || o == MD_MTLO) begin
            run_mt(o, a);
            read_hilo(hi, lo);
            dz = div_zero;
            lat = W + 3;
         end else begin
            run_op(o, a, b, lat, bcnt, hi, lo, dz);
         end
         model_op(o, a, b);
         checks++; if (lat !== W + 3) begin errors++; $display("FAIL rnd%0d_latency op=%0d got %0d exp %0d", n, o, lat, W + 3); end
         checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h:%h exp %h:%h", n, o, a, b, hi, lo, m_hi, m_lo); end
         checks++; if (dz !== m_dz) begin errors++; $display("FAIL rnd%0d_div_zero got %b exp %b", n, dz, m_dz); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_accum();
      test_mf_stall();
      test_back_to_back();
      test_abort();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
